// File: rtl/bsg_async_ptr_pkg.sv
// ---------------------------------------------------------------------------
// bsg_async_ptr_pkg
// Shared helpers for the async FIFO pointer logic: pointer width and
// binary <-> gray conversions. The conversion functions operate on 32-bit
// values. Callers zero-extend narrower pointers and cast the result back
// down. Upper zero bits do not disturb either conversion.
// ---------------------------------------------------------------------------
package bsg_async_ptr_pkg;

    // A pointer carries one extra wrap bit so that full and empty can be
    // told apart.
    function automatic int ptr_width(input int lg_size);
        return lg_size + 1;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/bsg_async_ptr_rx_if.sv
// ---------------------------------------------------------------------------
// bsg_async_ptr_rx_if
// Groups the read-side signals of the async FIFO pointer tracker.
//   w_ptr_gray_sync : synchronized gray write pointer (into tracker)
//   yumi            : consumer dequeues head entry (into tracker)
//   valid/count     : non-empty flag and occupancy (from tracker)
//   r_addr          : RAM read address (from tracker)
//   r_ptr_gray      : registered gray read pointer (from tracker)
//   error           : sticky protocol error (from tracker)
// Modports: master = consumer/synchronizer side, slave = tracker side.
// ---------------------------------------------------------------------------
interface bsg_async_ptr_rx_if
    import bsg_async_ptr_pkg::*;
#(
    parameter int lg_size_p = 3
);
    localparam int ptr_w_lp = ptr_width(lg_size_p);

    logic [ptr_w_lp-1:0]  w_ptr_gray_sync;
    logic                 yumi;
    logic                 valid;
    logic [ptr_w_lp-1:0]  count;
    logic [lg_size_p-1:0] r_addr;
    logic [ptr_w_lp-1:0]  r_ptr_gray;
    logic                 error;

    modport master (
        output w_ptr_gray_sync, yumi,
        input  valid, count, r_addr, r_ptr_gray, error
    );

    modport slave (
        input  w_ptr_gray_sync, yumi,
        output valid, count, r_addr, r_ptr_gray, error
    );
endinterface

// File: rtl/bsg_gray_to_binary.sv
// ---------------------------------------------------------------------------
// bsg_gray_to_binary
// Combinational gray -> binary converter of parameterized width.
//   gray_i : gray-coded input, width_p bits
//   bin_o  : binary output, width_p bits
// ---------------------------------------------------------------------------
module bsg_gray_to_binary
    import bsg_async_ptr_pkg::*;
#(
    parameter int width_p = 4
) (
    input  logic [width_p-1:0] gray_i,
    output logic [width_p-1:0] bin_o
);
    assign bin_o = width_p'(gray2bin(32'(gray_i)));
endmodule

// File: rtl/bsg_async_ptr_rx.sv
// ---------------------------------------------------------------------------
// bsg_async_ptr_rx
// Read-domain pointer tracker for an async FIFO. It converts the synchronized
// gray write pointer to binary, keeps the local read pointer, reports
// occupancy and valid, drives the RAM read address, and returns a registered
// gray read pointer to the write domain.
//
// Ports:
//   clk_i             read-domain clock
//   reset_i           synchronous active-high reset
//   w_ptr_gray_sync_i synchronized gray write pointer (lg_size_p+1 bits)
//   yumi_i            consumer dequeues head entry
//   valid_o           FIFO non-empty
//   count_o           occupancy 0..2^lg_size_p
//   r_addr_o          RAM read address (read pointer low bits)
//   r_ptr_gray_o      registered gray read pointer
//   error_o           sticky protocol error
//
// Optional feature macro: BSG_ASYNC_PTR_RX_CHECK_EN
//   When defined, error_o latches when the gray input changes in more than
//   one bit between cycles, or when occupancy exceeds the FIFO depth.
//   When undefined, error_o is tied low and no checker state is built.
// ---------------------------------------------------------------------------
module bsg_async_ptr_rx
    import bsg_async_ptr_pkg::*;
#(
    parameter int lg_size_p = 3
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [lg_size_p:0]   w_ptr_gray_sync_i,
    input  logic                 yumi_i,
    output logic                 valid_o,
    output logic [lg_size_p:0]   count_o,
    output logic [lg_size_p-1:0] r_addr_o,
    output logic [lg_size_p:0]   r_ptr_gray_o,
    output logic                 error_o
);
    localparam int ptr_w_lp = ptr_width(lg_size_p);

    logic [ptr_w_lp-1:0] w_bin_d, w_bin_q;
    logic [ptr_w_lp-1:0] r_bin_d, r_bin_q;
    logic [ptr_w_lp-1:0] r_gray_d, r_gray_q;
    logic                deq;

    bsg_gray_to_binary #(
        .width_p(ptr_w_lp)
    ) w_g2b (
        .gray_i(w_ptr_gray_sync_i),
        .bin_o (w_bin_d)
    );

    // Modular subtraction keeps the count continuous across pointer wrap.
    assign count_o  = w_bin_q - r_bin_q;
    assign valid_o  = (count_o != '0);
    assign deq      = yumi_i & valid_o;
    assign r_bin_d  = r_bin_q + ptr_w_lp'(deq);
    // Gray is derived from the next binary value so that the returned
    // pointer moves in the same cycle as r_bin_q.
    assign r_gray_d = ptr_w_lp'(bin2gray(32'(r_bin_d)));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            w_bin_q  <= '0;
            r_bin_q  <= '0;
            r_gray_q <= '0;
        end else begin
            w_bin_q  <= w_bin_d;
            r_bin_q  <= r_bin_d;
            r_gray_q <= r_gray_d;
        end
    end

    assign r_addr_o     = r_bin_q[lg_size_p-1:0];
    assign r_ptr_gray_o = r_gray_q;

`ifdef BSG_ASYNC_PTR_RX_CHECK_EN
    localparam logic [ptr_w_lp-1:0] depth_lp = ptr_w_lp'(1 << lg_size_p);

    logic [ptr_w_lp-1:0] w_gray_prev_q;
    logic [ptr_w_lp-1:0] w_gray_diff;
    logic                multi_bit;
    logic                overfull;
    logic                err_q;

    assign w_gray_diff = w_ptr_gray_sync_i ^ w_gray_prev_q;
    // Clearing the lowest set bit leaves a nonzero value only when two or
    // more bits changed.
    assign multi_bit   = ((w_gray_diff & (w_gray_diff - ptr_w_lp'(1))) != '0);
    assign overfull    = (count_o > depth_lp);

    // The previous-value register tracks the input during reset as well.
    // The first compare after reset therefore sees a settled reference.
    always_ff @(posedge clk_i) begin
        w_gray_prev_q <= w_ptr_gray_sync_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_q <= 1'b0;
        end else if (multi_bit || overfull) begin
            err_q <= 1'b1;
        end
    end

    assign error_o = err_q;
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_async_ptr_rx.sv
module tb_bsg_async_ptr_rx;
    localparam int LG = 3;
`ifdef BSG_ASYNC_PTR_RX_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    bsg_async_ptr_rx_if #(.lg_size_p(LG)) bus ();

    bsg_async_ptr_rx #(.lg_size_p(LG)) dut (
        .clk_i            (clk),
        .reset_i          (rst),
        .w_ptr_gray_sync_i(bus.w_ptr_gray_sync),
        .yumi_i           (bus.yumi),
        .valid_o          (bus.valid),
        .count_o          (bus.count),
        .r_addr_o         (bus.r_addr),
        .r_ptr_gray_o     (bus.r_ptr_gray),
        .error_o          (bus.error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] w;
        logic       y;
        logic       ev;
        logic [3:0] ec;
        logic [2:0] ea;
        logic [3:0] eg;
        logic       ee;
    } vec_t;

    vec_t vt[11];

    function automatic logic [3:0] gray(input int b);
        logic [3:0] x;
        x = b[3:0];
        return x ^ (x >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [3:0] w, input logic y);
        rst = r;
        bus.w_ptr_gray_sync = w;
        bus.yumi = y;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        drive(1'b1, 4'b0110, 1'b0);

        //         rst  w        y     ev    ec  ea  eg       ee
        vt[0]  = '{1'b1, 4'b0110, 1'b0, 1'b0, 0, 0, 4'b0000, 1'b0};
        vt[1]  = '{1'b1, 4'b0110, 1'b0, 1'b0, 0, 0, 4'b0000, 1'b0};
        vt[2]  = '{1'b0, 4'b0110, 1'b0, 1'b1, 4, 0, 4'b0000, 1'b0};
        vt[3]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 0, 0, 4'b0000, 1'b0};
        vt[4]  = '{1'b0, 4'b0001, 1'b0, 1'b1, 1, 0, 4'b0000, 1'b0};
        vt[5]  = '{1'b0, 4'b0011, 1'b0, 1'b1, 2, 0, 4'b0000, 1'b0};
        vt[6]  = '{1'b0, 4'b0010, 1'b0, 1'b1, 3, 0, 4'b0000, 1'b0};
        vt[7]  = '{1'b0, 4'b0010, 1'b1, 1'b1, 2, 1, 4'b0001, 1'b0};
        vt[8]  = '{1'b0, 4'b0010, 1'b1, 1'b1, 1, 2, 4'b0011, 1'b0};
        vt[9]  = '{1'b0, 4'b0010, 1'b1, 1'b0, 0, 3, 4'b0010, 1'b0};
        vt[10] = '{1'b0, 4'b0010, 1'b1, 1'b0, 0, 3, 4'b0010, 1'b0};

        for (int i = 0; i < 11; i++) begin
            drive(vt[i].rst, vt[i].w, vt[i].y);
            tick();
            chk($sformatf("vec%0d.valid", i), 32'(bus.valid), 32'(vt[i].ev));
            chk($sformatf("vec%0d.count", i), 32'(bus.count), 32'(vt[i].ec));
            chk($sformatf("vec%0d.r_addr", i), 32'(bus.r_addr), 32'(vt[i].ea));
            chk($sformatf("vec%0d.r_gray", i), 32'(bus.r_ptr_gray), 32'(vt[i].eg));
            chk($sformatf("vec%0d.error", i), 32'(bus.error), 32'(vt[i].ee));
        end

        // Full: walk the write pointer one step per cycle up to depth.
        drive(1'b1, 4'b0000, 1'b0);
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            bus.w_ptr_gray_sync = gray(k);
            tick();
        end
        chk("full.count", 32'(bus.count), 32'd8);
        chk("full.valid", 32'(bus.valid), 32'd1);
        chk("full.error", 32'(bus.error), 32'd0);
        chk("full.r_addr", 32'(bus.r_addr), 32'd0);

        // Wrap: move both pointers together until read=15, write=1.
        drive(1'b1, 4'b0000, 1'b0);
        tick();
        drive(1'b0, gray(1), 1'b0);
        tick();
        for (int k = 2; k <= 16; k++) begin
            drive(1'b0, gray(k), 1'b1);
            tick();
        end
        drive(1'b0, gray(1), 1'b0);
        tick();
        chk("wrap0.count", 32'(bus.count), 32'd2);
        chk("wrap0.r_gray", 32'(bus.r_ptr_gray), 32'b1000);
        chk("wrap0.r_addr", 32'(bus.r_addr), 32'd7);
        bus.yumi = 1'b1;
        tick();
        chk("wrap1.count", 32'(bus.count), 32'd1);
        chk("wrap1.r_gray", 32'(bus.r_ptr_gray), 32'd0);
        chk("wrap1.r_addr", 32'(bus.r_addr), 32'd0);
        tick();
        chk("wrap2.count", 32'(bus.count), 32'd0);
        chk("wrap2.valid", 32'(bus.valid), 32'd0);
        chk("wrap2.r_gray", 32'(bus.r_ptr_gray), 32'd1);

        // Simultaneous write advance and dequeue (read=1, write=1 here).
        bus.yumi = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            bus.w_ptr_gray_sync = gray(k);
            tick();
        end
        chk("simul0.count", 32'(bus.count), 32'd3);
        chk("simul0.r_addr", 32'(bus.r_addr), 32'd1);
        drive(1'b0, gray(5), 1'b1);
        tick();
        chk("simul1.count", 32'(bus.count), 32'd3);
        chk("simul1.r_addr", 32'(bus.r_addr), 32'd2);
        chk("simul1.r_gray", 32'(bus.r_ptr_gray), 32'b0011);

        // Checker: two-bit jump on the gray input.
        drive(1'b1, 4'b0000, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        chk("chk.pre", 32'(bus.error), 32'd0);
        bus.w_ptr_gray_sync = 4'b0011;
        tick();
        chk("chk.set", 32'(bus.error), 32'(CHK));
        tick();
        tick();
        chk("chk.hold", 32'(bus.error), 32'(CHK));
        rst = 1'b1;
        tick();
        chk("chk.clear", 32'(bus.error), 32'd0);
        chk("chk.count", 32'(bus.count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
